// File: rtl/multicycle_control_if.sv
// Memory handshake between the multicycle controller (master) and the memory port (slave).
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32 subset core: fetch, decode, execute, memory, writeback.
// Control outputs are decoded from the state, plus mem_ready during FETCH.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master mem,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 trap,
    output logic [31:0]          retired
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    state_t state;
    logic   is_r, is_i, is_load, is_store, is_branch, is_jal;
    logic   branch_ok, legal, taken;
    logic   mem_req, mem_we;

    // The opcode is only looked at once the instruction register has been loaded,
    // so whatever sits on it during FETCH is irrelevant.
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign legal     = is_r || is_i || is_load || is_store || is_jal || (is_branch && branch_ok);
    assign taken     = is_branch && (((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            retired <= 32'd0;
            trap    <= 1'b0;
        end else begin
            case (state)
                FETCH:  if (mem.mem_ready) state <= DECODE;
                DECODE: begin
                    if (legal) begin
                        state <= EXEC;
                    end else begin
                        state <= TRAP;
                        trap  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_load || is_store) begin
                        state <= MEM;
                    end else if (is_branch) begin
                        state   <= FETCH;
                        retired <= retired + 32'd1;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (mem.mem_ready) begin
                        if (is_load) begin
                            state <= WB;
                        end else begin
                            state   <= FETCH;
                            retired <= retired + 32'd1;
                        end
                    end
                end
                WB: begin
                    state   <= FETCH;
                    retired <= retired + 32'd1;
                end
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // Fetch strobes are gated by reset so a held-in-reset core never loads IR/PC.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_src   = 1'b0;
        alu_op    = 2'd0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem.mem_ready && reset) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            EXEC: begin
                if (is_r) begin
                    alu_op = 2'd2;
                end else if (is_i) begin
                    alu_src = 1'b1;
                    alu_op  = 2'd2;
                end else if (is_load || is_store) begin
                    alu_src = 1'b1;
                end else if (is_branch) begin
                    alu_op = 2'd1;
                    if (taken) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd1;
                    end
                end else if (is_jal) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
            end
            WB: begin
                reg_write = 1'b1;
                if (is_load) begin
                    wb_sel = 2'd1;
                end else if (is_jal) begin
                    wb_sel = 2'd2;
                end
            end
            default: ;
        endcase
    end

    assign mem.mem_req = mem_req;
    assign mem.mem_we  = mem_we;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction scoreboard driven from a vector
// table, plus hand-written trap, mid-instruction reset and retired-wrap sequences.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        ir_write, pc_write, alu_src, reg_write, trap;
    logic [1:0]  pc_src, alu_op, wb_sel;
    logic [31:0] retired;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk       (clk),
        .reset     (reset),
        .mem       (bus),
        .opcode    (opcode),
        .funct3    (funct3),
        .zero      (zero),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .trap      (trap),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       zero_in;
        int         fetch_wait;
        int         data_wait;
        int         cycles;
        int         reg_writes;
        logic [1:0] wb;
        logic       pcw;
        logic [1:0] pcs;
        int         mem_cycles;
        logic       we;
    } vec_t;

    vec_t        vecs[12];
    vec_t        sb_q[$];
    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [31:0] exp_retired;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input vec_t obs, input int bad);
        vec_t exp;
        exp = sb_q.pop_front();
        exp_retired = exp_retired + 32'd1;
        check({tag, "_cycles"},     obs.cycles,     exp.cycles);
        check({tag, "_reg_writes"}, obs.reg_writes, exp.reg_writes);
        check({tag, "_wb_sel"},     obs.wb,         exp.wb);
        check({tag, "_pc_write"},   obs.pcw,        exp.pcw);
        check({tag, "_pc_src"},     obs.pcs,        exp.pcs);
        check({tag, "_mem_cycles"}, obs.mem_cycles, exp.mem_cycles);
        check({tag, "_mem_we"},     obs.we,         exp.we);
        check({tag, "_invariants"}, bad,            0);
        check({tag, "_retired"},    retired,        exp_retired);
    endtask

    // Runs one instruction from FETCH; the opcode only appears after the IR load edge.
    task automatic apply_stimulus(input string tag, input vec_t v);
        vec_t        obs;
        int          fw, dw, bad;
        bit          fetched, done, acc;
        logic [31:0] prev;
        sb_q.push_back(v);
        obs = v;
        obs.cycles = 0; obs.reg_writes = 0; obs.wb = 2'd0; obs.pcw = 1'b0;
        obs.pcs = 2'd0; obs.mem_cycles = 0; obs.we = 1'b0;
        fw = v.fetch_wait; dw = v.data_wait; bad = 0;
        fetched = 1'b0; done = 1'b0; prev = retired;
        opcode = 7'h7F; funct3 = 3'b111; zero = v.zero_in;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            if (bus.mem_req) begin
                if (!fetched) begin
                    if (fw == 0) bus.mem_ready = 1'b1; else fw--;
                end else begin
                    obs.mem_cycles++;
                    if (bus.mem_we) obs.we = 1'b1;
                    if (dw == 0) bus.mem_ready = 1'b1; else dw--;
                end
            end
            #1;
            acc = ir_write;
            if (reg_write) begin
                obs.reg_writes++;
                obs.wb = wb_sel;
            end
            if (pc_write && fetched) begin
                obs.pcw = 1'b1;
                obs.pcs = pc_src;
            end
            if (reg_write && pc_write) bad++;
            if (bus.mem_req && reg_write) bad++;
            if (!fetched && (bus.mem_we || reg_write)) bad++;
            @(posedge clk);
            #1;
            if (acc && !fetched) begin
                fetched = 1'b1;
                opcode  = v.op;
                funct3  = v.f3;
            end
            if (retired !== prev) begin
                done       = 1'b1;
                obs.cycles = cyc;
            end
        end
        bus.mem_ready = 1'b0;
        check_output(tag, obs, bad);
    endtask

    task automatic trap_sequence(input string tag, input logic [6:0] op, input logic [2:0] f3, input int n);
        @(negedge clk);
        opcode = 7'b0110011; funct3 = 3'b000;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        opcode = op; funct3 = f3; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            check({tag, "_outputs"}, {26'd0, trap, bus.mem_req, bus.mem_we, ir_write, pc_write, reg_write},
                  32'b100000);
            check({tag, "_retired"}, retired, exp_retired);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check({tag, "_cleared"}, {30'd0, trap, bus.mem_req}, 32'b01);
        check({tag, "_retired_reset"}, retired, 32'd0);
        exp_retired = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        //              op          f3      z     fw dw cyc rw wb    pcw   pcs   mc we
        vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 0, 0, 4, 1, 2'd0, 1'b0, 2'd0, 0, 1'b0};
        vecs[1]  = '{7'b0010011, 3'b101, 1'b0, 1, 0, 5, 1, 2'd0, 1'b0, 2'd0, 0, 1'b0};
        vecs[2]  = '{7'b0000011, 3'b010, 1'b0, 0, 2, 7, 1, 2'd1, 1'b0, 2'd0, 3, 1'b0};
        vecs[3]  = '{7'b0000011, 3'b010, 1'b0, 0, 0, 5, 1, 2'd1, 1'b0, 2'd0, 1, 1'b0};
        vecs[4]  = '{7'b0100011, 3'b010, 1'b0, 0, 0, 4, 0, 2'd0, 1'b0, 2'd0, 1, 1'b1};
        vecs[5]  = '{7'b0100011, 3'b010, 1'b0, 1, 1, 6, 0, 2'd0, 1'b0, 2'd0, 2, 1'b1};
        vecs[6]  = '{7'b1100011, 3'b000, 1'b1, 0, 0, 3, 0, 2'd0, 1'b1, 2'd1, 0, 1'b0};
        vecs[7]  = '{7'b1100011, 3'b000, 1'b0, 0, 0, 3, 0, 2'd0, 1'b0, 2'd0, 0, 1'b0};
        vecs[8]  = '{7'b1100011, 3'b001, 1'b0, 0, 0, 3, 0, 2'd0, 1'b1, 2'd1, 0, 1'b0};
        vecs[9]  = '{7'b1100011, 3'b001, 1'b1, 0, 0, 3, 0, 2'd0, 1'b0, 2'd0, 0, 1'b0};
        vecs[10] = '{7'b1101111, 3'b000, 1'b0, 0, 0, 4, 1, 2'd2, 1'b1, 2'd2, 0, 1'b0};
        vecs[11] = '{7'b0110011, 3'b111, 1'b0, 2, 0, 6, 1, 2'd0, 1'b0, 2'd0, 0, 1'b0};

        // Held in reset with memory ready: FETCH decode, but no IR/PC load.
        reset = 1'b0; bus.mem_ready = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; zero = 1'b0;
        exp_retired = 32'd0;
        #3;
        check("reset_outputs", {26'd0, bus.mem_req, bus.mem_we, ir_write, pc_write, reg_write, trap}, 32'b100000);
        check("reset_misc", {25'd0, pc_src, alu_src, alu_op, wb_sel}, 32'd0);
        check("reset_retired", retired, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_retired", retired, 32'd0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Store aborted by reset while waiting in MEM.
        @(negedge clk);
        opcode = 7'h7F; funct3 = 3'b111;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        opcode = 7'b0100011; funct3 = 3'b010; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("store_mem_wait", {30'd0, bus.mem_req, bus.mem_we}, 32'b11);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_outputs", {27'd0, bus.mem_req, bus.mem_we, ir_write, pc_write, reg_write}, 32'b10000);
        check("abort_retired", retired, 32'd0);
        bus.mem_ready = 1'b1;
        #1;
        check("abort_gated", {30'd0, ir_write, pc_write}, 32'd0);
        exp_retired = 32'd0;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        apply_stimulus("after_abort", vecs[0]);

        trap_sequence("trap_ff", 7'b1111111, 3'b000, 20);
        trap_sequence("trap_bfunct", 7'b1100011, 3'b010, 3);

        // Preload the retire counter just below wrap, then retire one more.
        apply_stimulus("pre_wrap", vecs[4]);
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        exp_retired = 32'hFFFF_FFFF;
        apply_stimulus("wrap", vecs[0]);
        apply_stimulus("post_wrap", vecs[6]);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
